// File: rtl/dac_sample_scheduler_pkg.sv
// Shared constants, state encoding and sample conversion for the DAC sample scheduler.
package dac_sample_scheduler_pkg;

    localparam int         SAMPLE_INTERVAL = 1500;
    localparam int         SAMPLE_W        = 32;
    localparam int         DAC_WORD_W      = 24;
    localparam logic [7:0] DAC_CMD_CH_A    = 8'b00110001;

    typedef enum logic {S_WAIT_PRIME, S_RUN} state_t;

    typedef struct packed {
        logic        clip;
        logic [15:0] word;
    } conv_t;

    // Offset binary is sat + 0x8000 modulo 2^16, which is just the sign bit flipped.
    function automatic conv_t sat16_offset(input logic signed [SAMPLE_W-1:0] x, input int shift);
        logic signed [SAMPLE_W-1:0] s;
        conv_t                      r;
        s      = x >>> shift;
        r.clip = 1'b0;
        r.word = s[15:0] ^ 16'h8000;
        if (s > 32'sd32767) begin
            r.clip = 1'b1;
            r.word = 16'hFFFF;
        end else if (s < -32'sd32768) begin
            r.clip = 1'b1;
            r.word = 16'h0000;
        end
        return r;
    endfunction

endpackage

// File: rtl/dac_sample_scheduler_fifo.sv
// Synchronous FIFO with registered occupancy; head entry is visible combinationally.
// Push while full and pop while empty are ignored.
module dac_sample_scheduler_fifo #(
    parameter int W  = 24,
    parameter int AW = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_head_dat,
    output logic [AW:0]  o_count
);
    localparam int DEPTH = 2**AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push     = i_push && (r_count != (AW+1)'(DEPTH));
    assign w_pop      = i_pop && (r_count != '0);
    assign o_head_dat = r_mem[r_rd];
    assign o_count    = r_count;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr] <= i_push_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Converts accumulated samples to DAC words, buffers them, and releases one word per sample
// period; an empty FIFO at release time repeats the previous word and flags an underrun.
module dac_sample_scheduler #(
    parameter int         SAMPLE_INTERVAL = dac_sample_scheduler_pkg::SAMPLE_INTERVAL,
    parameter int         SHIFT           = 2,
    parameter int         FIFO_AW         = 2,
    parameter logic [7:0] DAC_CMD         = dac_sample_scheduler_pkg::DAC_CMD_CH_A
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [31:0] in_sample,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               dac_busy,
    output logic [23:0]        dac_data,
    output logic               dac_send,
    output logic [FIFO_AW:0]   fill_level,
    output logic               underrun,
    output logic               clip
);
    import dac_sample_scheduler_pkg::*;

    localparam int DEPTH = 2**FIFO_AW;
    localparam int TW    = $clog2(SAMPLE_INTERVAL + 1);

    logic [TW-1:0]    r_timer;
    state_t           r_state;
    logic             r_pending;
    logic [23:0]      r_last_word;
    logic [23:0]      r_dac_data;
    logic             r_dac_send;
    logic             r_underrun;
    logic             r_clip;

    logic             w_tick;
    logic             w_push;
    conv_t            w_conv;
    logic [23:0]      w_entry;
    logic [23:0]      w_head;
    logic [FIFO_AW:0] w_fill;
    logic             w_empty;
    logic             w_active;
    logic             w_pend;
    logic             w_fire;
    logic             w_pop;

    assign w_tick  = (r_timer == TW'(SAMPLE_INTERVAL - 1));
    assign w_push  = in_valid && in_ready;
    assign w_conv  = sat16_offset(in_sample, SHIFT);
    assign w_entry = {DAC_CMD, w_conv.word};
    assign w_empty = (w_fill == '0);

    // The priming tick counts as a run-state tick so the first word goes out on it.
    assign w_active = (r_state == S_RUN) || (w_tick && !w_empty);
    assign w_pend   = r_pending || (w_tick && w_active);
    assign w_fire   = w_active && w_pend && !dac_busy;
    assign w_pop    = w_fire && !w_empty;

    dac_sample_scheduler_fifo #(
        .W  (24),
        .AW (FIFO_AW)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (w_entry),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_fill)
    );

    assign in_ready   = (w_fill != (FIFO_AW+1)'(DEPTH));
    assign fill_level = w_fill;
    assign dac_data   = r_dac_data;
    assign dac_send   = r_dac_send;
    assign underrun   = r_underrun;
    assign clip       = r_clip;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timer     <= '0;
            r_state     <= S_WAIT_PRIME;
            r_pending   <= 1'b0;
            r_last_word <= '0;
            r_dac_data  <= '0;
            r_dac_send  <= 1'b0;
            r_underrun  <= 1'b0;
            r_clip      <= 1'b0;
        end else begin
            r_timer    <= w_tick ? '0 : r_timer + 1'b1;
            r_clip     <= w_push && w_conv.clip;
            r_dac_send <= 1'b0;
            r_underrun <= 1'b0;
            if (r_state == S_WAIT_PRIME && w_tick && !w_empty) begin
                r_state <= S_RUN;
            end
            if (w_fire) begin
                r_dac_send <= 1'b1;
                r_pending  <= 1'b0;
                if (!w_empty) begin
                    r_dac_data  <= w_head;
                    r_last_word <= w_head;
                end else begin
                    r_dac_data <= r_last_word;
                    r_underrun <= 1'b1;
                end
            end else begin
                // A tick while still pending leaves a single outstanding send.
                r_pending <= w_pend;
            end
        end
    end

endmodule
